// File: rtl/board_scanner_if.sv
// rtl/board_scanner_if.sv - board scanner request/result and memory read bundle
interface board_scanner_if #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [COLS-1:0]   rd_data;
  logic [ADDR_W-1:0] address;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic [ROWS-1:0]   full_mask;
  logic [ADDR_W-1:0] full_count;
  logic [ADDR_W-1:0] top_row;
  logic              overflow;

  // The scanner itself.
  modport slave (
    input  start, rd_data,
    output address, rd_en, busy, done, full_mask, full_count, top_row, overflow
  );

  // Control FSM plus board memory side.
  modport master (
    output start, rd_data,
    input  address, rd_en, busy, done, full_mask, full_count, top_row, overflow
  );
endinterface

// File: rtl/board_scanner.sv
// rtl/board_scanner.sv - scans board rows for full lines, top occupied row and overflow
module board_scanner #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  board_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] NUM_ROWS  = ADDR_W'(ROWS);
  localparam logic [ROWS-1:0]   MASK_ONE  = ROWS'(1);

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_address;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;

  // Read-qualifier pipeline: rd_data belongs to the address issued one cycle earlier.
  logic              r_rd_v;
  logic [ADDR_W-1:0] r_rd_a;

  logic [ROWS-1:0]   r_full_mask;
  logic [ADDR_W-1:0] r_full_count;
  logic [ADDR_W-1:0] r_top_row;
  logic              r_overflow;

  logic              w_start_accept;
  logic              w_last_addr;
  logic              w_row_full;
  logic              w_row_any;

  assign w_start_accept = (r_state == IDLE) && bus.start;
  assign w_last_addr    = (r_address == LAST_ROW);
  // Only an exact all-ones row is full; any unknown bit makes the compare fail.
  assign w_row_full     = (bus.rd_data == {COLS{1'b1}});
  assign w_row_any      = (bus.rd_data != '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE, so a start while busy is dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SCAN;
      SCAN:    if (w_last_addr) w_state_next = DRAIN;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered address/strobe and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_address <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_address <= '0;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (w_last_addr) begin
            r_rd_en   <= 1'b0;
            r_address <= '0;
          end else begin
            r_address <= r_address + 1'b1;
          end
        end
        DRAIN: begin
          r_done <= 1'b1;
        end
        DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Delay strobe and address by one cycle to line up with returning rd_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_v <= 1'b0;
      r_rd_a <= '0;
    end else begin
      r_rd_v <= r_rd_en;
      r_rd_a <= r_address;
    end
  end

  // Result accumulation: cleared when a scan is accepted, updated per returned row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full_mask  <= '0;
      r_full_count <= '0;
      r_top_row    <= NUM_ROWS;
      r_overflow   <= 1'b0;
    end else if (w_start_accept) begin
      r_full_mask  <= '0;
      r_full_count <= '0;
      r_top_row    <= NUM_ROWS;
      r_overflow   <= 1'b0;
    end else if (r_rd_v) begin
      if (w_row_full) begin
        r_full_mask <= r_full_mask | (MASK_ONE << r_rd_a);
        if (r_full_count != NUM_ROWS) begin
          r_full_count <= r_full_count + 1'b1;
        end
      end
      // Rows arrive top-first, so the first non-empty row seen is the highest one.
      if (w_row_any && (r_top_row == NUM_ROWS)) begin
        r_top_row <= r_rd_a;
      end
      if (w_row_any && (r_rd_a == '0)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.address    = r_address;
  assign bus.rd_en      = r_rd_en;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.full_mask  = r_full_mask;
  assign bus.full_count = r_full_count;
  assign bus.top_row    = r_top_row;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_board_scanner.sv
// tb/tb_board_scanner.sv - directed table-driven bench for board_scanner
module tb_board_scanner;
  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int ADDR_W = 5;
  localparam int NVEC   = 6;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  board_scanner_if #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) bus ();

  board_scanner #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [COLS-1:0] mem [ROWS];

  // Board memory: synchronous read, data one cycle after the address/rd_en cycle.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.address];
  end

  typedef struct {
    logic [ROWS*COLS-1:0] board;
    logic [ROWS-1:0]      mask;
    int                   count;
    int                   top;
    int                   ovf;
  } vec_t;

  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string what, input int idx, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %0h expected %0h", what, idx, act, exp);
    end
  endtask

  function automatic void put(input int v, input int r, input logic [COLS-1:0] d);
    tbl[v].board[r*COLS +: COLS] = d;
  endfunction

  task automatic load(input int v);
    for (int r = 0; r < ROWS; r++) mem[r] = tbl[v].board[r*COLS +: COLS];
  endtask

  task automatic chk_results(input string what, input int v);
    chk({what, "_mask"},  v, bus.full_mask,  tbl[v].mask);
    chk({what, "_count"}, v, bus.full_count, tbl[v].count);
    chk({what, "_top"},   v, bus.top_row,    tbl[v].top);
    chk({what, "_ovf"},   v, bus.overflow,   tbl[v].ovf);
  endtask

  task automatic run_vector(input int v);
    int done_at;
    int addr_bad;
    done_at  = 0;
    addr_bad = 0;
    load(v);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n <= ROWS) begin
        if (bus.rd_en !== 1'b1 || bus.address !== ADDR_W'(n - 1) || bus.busy !== 1'b1) addr_bad++;
      end else if (bus.rd_en !== 1'b0 || bus.busy !== 1'b1) begin
        addr_bad++;
      end
      if (bus.done === 1'b1) begin
        done_at = n;
        break;
      end
      @(negedge clk);
    end
    chk("done_latency", v, done_at, 22);
    chk("addr_seq", v, addr_bad, 0);
    chk_results("result", v);
    @(negedge clk);
    chk("done_width", v, bus.done, 0);
    chk("busy_fall", v, bus.busy, 0);
    repeat (10) @(negedge clk);
    chk_results("held", v);
    chk("idle_busy", v, bus.busy, 0);
  endtask

  initial begin
    int dones;
    int done_n;
    int first_n;
    int second_n;
    int idle_n;

    for (int v = 0; v < NVEC; v++) begin
      tbl[v].board = '0;
    end
    // 0: empty board
    tbl[0].mask = 20'h00000; tbl[0].count = 0;  tbl[0].top = 20; tbl[0].ovf = 0;
    // 1: rows 18,19 full, row 17 partial
    put(1, 17, 10'b0000110000); put(1, 18, 10'h3FF); put(1, 19, 10'h3FF);
    tbl[1].mask = 20'hC0000; tbl[1].count = 2;  tbl[1].top = 17; tbl[1].ovf = 0;
    // 2: game over, row 0 occupied, row 5 full
    put(2, 0, 10'b0000100000); put(2, 5, 10'h3FF);
    tbl[2].mask = 20'h00020; tbl[2].count = 1;  tbl[2].top = 0;  tbl[2].ovf = 1;
    // 3: every row full
    for (int r = 0; r < ROWS; r++) put(3, r, 10'h3FF);
    tbl[3].mask = 20'hFFFFF; tbl[3].count = 20; tbl[3].top = 0;  tbl[3].ovf = 1;
    // 4: near-full row 7 is not full, row 12 full, single bit in row 19
    put(4, 7, 10'h3FE); put(4, 12, 10'h3FF); put(4, 19, 10'h001);
    tbl[4].mask = 20'h01000; tbl[4].count = 1;  tbl[4].top = 7;  tbl[4].ovf = 0;
    // 5: rows 1 and 10 full, row 0 empty
    put(5, 1, 10'h3FF); put(5, 10, 10'h3FF);
    tbl[5].mask = 20'h00402; tbl[5].count = 2;  tbl[5].top = 1;  tbl[5].ovf = 0;

    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_address", 0, bus.address, 0);
    chk("rst_rd_en", 0, bus.rd_en, 0);
    chk("rst_busy", 0, bus.busy, 0);
    chk("rst_done", 0, bus.done, 0);
    chk("rst_mask", 0, bus.full_mask, 0);
    chk("rst_count", 0, bus.full_count, 0);
    chk("rst_top", 0, bus.top_row, 20);
    chk("rst_ovf", 0, bus.overflow, 0);

    for (int v = 0; v < NVEC; v++) run_vector(v);

    // Reset asserted in the 5th SCAN cycle of an all-full scan.
    load(3);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_address", 3, bus.address, 0);
    chk("midrst_rd_en", 3, bus.rd_en, 0);
    chk("midrst_busy", 3, bus.busy, 0);
    chk("midrst_mask", 3, bus.full_mask, 0);
    chk("midrst_count", 3, bus.full_count, 0);
    chk("midrst_top", 3, bus.top_row, 20);
    chk("midrst_ovf", 3, bus.overflow, 0);
    @(negedge clk) reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("midrst_no_done", 3, dones, 0);
    run_vector(3);

    // Second start pulse in cycle 3 of a scan must be ignored.
    load(1);
    dones  = 0;
    done_n = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 3) bus.start = 1'b1;
      if (n == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (done_n == 0) done_n = n;
      end
      @(negedge clk);
    end
    chk("busy_start_dones", 1, dones, 1);
    chk("busy_start_latency", 1, done_n, 22);
    chk_results("busy_start", 1);

    // Start held high: back-to-back scans with one idle cycle between them.
    load(2);
    first_n  = 0;
    second_n = 0;
    idle_n   = 0;
    @(negedge clk) bus.start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 24) begin
        chk("held_clear_count", 2, bus.full_count, 0);
        chk("held_clear_top", 2, bus.top_row, 20);
        chk("held_clear_ovf", 2, bus.overflow, 0);
      end
      if (first_n != 0 && bus.busy === 1'b0) idle_n++;
      if (bus.done === 1'b1) begin
        if (first_n == 0) begin
          first_n = n;
        end else begin
          second_n = n;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("held_first_done", 2, first_n, 22);
    chk("held_second_done", 2, second_n, 45);
    chk("held_idle_cycles", 2, idle_n, 1);
    chk_results("held_scan", 2);
    repeat (3) @(negedge clk);
    chk("held_stop_busy", 2, bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
